// File: rtl/trap_controller_pkg.sv
// Shared constants and types for the trap controller: CSR addresses,
// cause codes, FSM state encodings and the selected-event record.
package trap_controller_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [31:0] CAUSE_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;

    typedef enum logic [1:0] {
        TC_IDLE     = 2'd0,
        TC_FLUSH    = 2'd1,
        TC_REDIRECT = 2'd2
    } tc_state_e;

    // The single event chosen from the two writeback slots this cycle.
    typedef struct packed {
        logic        trap;
        logic        mret;
        logic        slot0;
        logic [31:0] pc;
        logic [31:0] cause;
    } tc_event_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Software CSR access bus: write strobe, address, write data and the
// combinational read data returned by the CSR block.
interface trap_controller_if;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;

    modport master (output csr_we_i, output csr_addr_i, output csr_wdata_i, input csr_rdata_o);
    modport slave  (input csr_we_i, input csr_addr_i, input csr_wdata_i, output csr_rdata_o);
endinterface

// File: rtl/trap_controller_csrs.sv
// Machine trap CSRs (mtvec, mepc, mcause): software write path, hardware
// trap update with priority over software, and the combinational read mux.
module trap_csrs
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    trap_controller_if.slave  csr,
    input  logic              hw_we_i,
    input  logic [31:0]       hw_mepc_i,
    input  logic [31:0]       hw_mcause_i,
    output logic [31:0]       mtvec_o,
    output logic [31:0]       mepc_o
);

    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    // Next-state: software write first, then a hardware trap overrides it.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (csr.csr_we_i) begin
            case (csr.csr_addr_i)
                CSR_MTVEC:  mtvec_d  = csr.csr_wdata_i;
                CSR_MEPC:   mepc_d   = word_align(csr.csr_wdata_i);
                CSR_MCAUSE: mcause_d = csr.csr_wdata_i;
                default:    ;
            endcase
        end
        if (hw_we_i) begin
            mepc_d   = hw_mepc_i;
            mcause_d = hw_mcause_i;
        end
    end

    // CSR state registers.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            mtvec_q  <= MTVEC_RESET;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        csr.csr_rdata_o = '0;
        case (csr.csr_addr_i)
            CSR_MTVEC:  csr.csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr.csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr.csr_rdata_o = mcause_q;
            default:    ;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_controller.sv
// Trap/mret sequencer for the dual-issue core: picks the oldest writeback
// event, kills younger writes, flushes, then redirects fetch.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trap0_i,
    input  logic              trap1_i,
    input  logic              misaligned_i,
    input  logic              mret0_i,
    input  logic              mret1_i,
    input  logic [31:0]       pc_0_i,
    input  logic [31:0]       pc_1_i,
    trap_controller_if.slave  csr_if,
    output logic              wb_kill0_o,
    output logic              wb_kill1_o,
    output logic              flush_o,
    output logic              stall_o,
    output logic              redirect_o,
    output logic [31:0]       redirect_pc_o
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    tc_state_e   state_q;
    logic [3:0]  flush_cnt_q;
    logic [31:0] target_q;
    logic        flush_q, stall_q, redirect_q;
    logic [31:0] redirect_pc_q;

    tc_event_t   ev;
    logic        take_trap, take_mret;
    logic [31:0] mtvec, mepc;

    // Oldest-event selection: slot0 wins if it has anything; trap beats mret.
    always_comb begin
        ev       = '0;
        ev.slot0 = trap0_i | mret0_i;
        ev.trap  = ev.slot0 ? trap0_i : trap1_i;
        ev.mret  = ev.slot0 ? (mret0_i & ~trap0_i) : (mret1_i & ~trap1_i);
        ev.pc    = ev.slot0 ? pc_0_i : pc_1_i;
        ev.cause = (ev.slot0 && misaligned_i) ? CAUSE_MISALIGNED : CAUSE_ILLEGAL;
    end

    // Events outside IDLE belong to wrong-path instructions and are ignored.
    assign take_trap  = (state_q == TC_IDLE) & ev.trap;
    assign take_mret  = (state_q == TC_IDLE) & ev.mret;
    assign wb_kill0_o = take_trap & ev.slot0;
    assign wb_kill1_o = take_trap | (take_mret & ev.slot0);

    trap_csrs #(.MTVEC_RESET(MTVEC_RESET)) u_csrs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .csr         (csr_if),
        .hw_we_i     (take_trap),
        .hw_mepc_i   (ev.pc),
        .hw_mcause_i (ev.cause),
        .mtvec_o     (mtvec),
        .mepc_o      (mepc)
    );

    // Sequencer FSM with registered flush/stall/redirect outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= TC_IDLE;
            flush_cnt_q   <= '0;
            target_q      <= '0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            unique case (state_q)
                TC_IDLE: begin
                    if (take_trap) begin
                        target_q <= word_align(mtvec);
                    end else if (take_mret) begin
                        target_q <= mepc;
                    end
                    if (take_trap || take_mret) begin
                        state_q     <= TC_FLUSH;
                        flush_q     <= 1'b1;
                        stall_q     <= 1'b1;
                        flush_cnt_q <= FLUSH_LAST;
                    end
                end
                TC_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q       <= TC_REDIRECT;
                        flush_q       <= 1'b0;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= target_q;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                TC_REDIRECT: begin
                    state_q    <= TC_IDLE;
                    redirect_q <= 1'b0;
                    stall_q    <= 1'b0;
                end
                default: state_q <= TC_IDLE;
            endcase
        end
    end

    assign flush_o       = flush_q;
    assign stall_o       = stall_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: a vector table of single events on a
// FLUSH_CYCLES=1 instance, hand sequences for wrong-path, same-cycle CSR
// writes, and a FLUSH_CYCLES=3 instance for the mid-flush reset case.
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap0, trap1, mis, mret0, mret1;
    logic [31:0] pc0, pc1;

    logic        k0_a, k1_a, fl_a, st_a, rd_a;
    logic [31:0] rpc_a;
    logic        k0_b, k1_b, fl_b, st_b, rd_b;
    logic [31:0] rpc_b;

    int total = 0;
    int bad   = 0;

    trap_controller_if if_a ();
    trap_controller_if if_b ();

    trap_controller #(.MTVEC_RESET(32'h0000_0000), .FLUSH_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .trap0_i(trap0), .trap1_i(trap1),
        .misaligned_i(mis), .mret0_i(mret0), .mret1_i(mret1),
        .pc_0_i(pc0), .pc_1_i(pc1), .csr_if(if_a),
        .wb_kill0_o(k0_a), .wb_kill1_o(k1_a), .flush_o(fl_a), .stall_o(st_a),
        .redirect_o(rd_a), .redirect_pc_o(rpc_a)
    );

    trap_controller #(.MTVEC_RESET(32'h0000_0100), .FLUSH_CYCLES(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .trap0_i(trap0), .trap1_i(trap1),
        .misaligned_i(mis), .mret0_i(mret0), .mret1_i(mret1),
        .pc_0_i(pc0), .pc_1_i(pc1), .csr_if(if_b),
        .wb_kill0_o(k0_b), .wb_kill1_o(k1_b), .flush_o(fl_b), .stall_o(st_b),
        .redirect_o(rd_b), .redirect_pc_o(rpc_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        t0, t1, mis, m0, m1;
        logic [31:0] pc0, pc1;
        logic        k0, k1;
        logic [31:0] mepc, mcause, target;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        trap0 = 1'b0; trap1 = 1'b0; mis = 1'b0; mret0 = 1'b0; mret1 = 1'b0;
    endtask

    task automatic csr_set(input logic we, input logic [11:0] addr, input logic [31:0] data);
        if_a.csr_we_i = we; if_a.csr_addr_i = addr; if_a.csr_wdata_i = data;
        if_b.csr_we_i = we; if_b.csr_addr_i = addr; if_b.csr_wdata_i = data;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        csr_set(1'b1, addr, data);
        tick();
        csr_set(1'b0, 12'h000, 32'h0);
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] a, output logic [31:0] b);
        csr_set(1'b0, addr, 32'h0);
        #1;
        a = if_a.csr_rdata_o;
        b = if_b.csr_rdata_o;
    endtask

    // One event on dut_a through the full T, flush, redirect, idle sequence.
    task automatic run_vec(input vec_t v);
        logic [31:0] ra, rb;
        trap0 = v.t0; trap1 = v.t1; mis = v.mis; mret0 = v.m0; mret1 = v.m1;
        pc0 = v.pc0; pc1 = v.pc1;
        #1;
        check({v.name, " kill0"}, 32'(k0_a), 32'(v.k0));
        check({v.name, " kill1"}, 32'(k1_a), 32'(v.k1));
        tick();
        clear_ev();
        check({v.name, " flush@T+1"}, 32'(fl_a), 32'd1);
        check({v.name, " stall@T+1"}, 32'(st_a), 32'd1);
        check({v.name, " redir@T+1"}, 32'(rd_a), 32'd0);
        tick();
        check({v.name, " flush@T+2"}, 32'(fl_a), 32'd0);
        check({v.name, " redir@T+2"}, 32'(rd_a), 32'd1);
        check({v.name, " rpc@T+2"}, rpc_a, v.target);
        tick();
        check({v.name, " redir@T+3"}, 32'(rd_a), 32'd0);
        check({v.name, " stall@T+3"}, 32'(st_a), 32'd0);
        check({v.name, " rpc hold"}, rpc_a, v.target);
        rd(CSR_MEPC, ra, rb);
        check({v.name, " mepc"}, ra, v.mepc);
        rd(CSR_MCAUSE, ra, rb);
        check({v.name, " mcause"}, ra, v.mcause);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int n;
        vec_t v;

        //             name           t0    t1    mis   m0    m1    pc0       pc1       k0    k1    mepc      mcause target
        vecs[0] = '{"slot0_ill",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h104, 1'b1, 1'b1, 32'h100, 32'd2, 32'h200};
        vecs[1] = '{"slot1_ill",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h104, 1'b0, 1'b1, 32'h104, 32'd2, 32'h200};
        vecs[2] = '{"both_mis",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h080, 32'h084, 1'b1, 1'b1, 32'h080, 32'd0, 32'h200};
        vecs[3] = '{"mret1",       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h090, 32'h094, 1'b0, 1'b0, 32'h080, 32'd0, 32'h080};
        vecs[4] = '{"mret0_trap1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h090, 32'h094, 1'b0, 1'b1, 32'h080, 32'd0, 32'h080};
        vecs[5] = '{"trap0_mret0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h040, 32'h044, 1'b1, 1'b1, 32'h040, 32'd2, 32'h200};
        vecs[6] = '{"mis_slot1",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0B0, 32'h0C0, 1'b0, 1'b1, 32'h0C0, 32'd2, 32'h200};

        rst = 1'b1;
        clear_ev();
        pc0 = '0; pc1 = '0;
        csr_set(1'b0, 12'h000, 32'h0);
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst kill0", 32'(k0_a), 32'd0);
        check("rst kill1", 32'(k1_a), 32'd0);
        check("rst flush", 32'(fl_a), 32'd0);
        check("rst stall", 32'(st_a), 32'd0);
        check("rst redir", 32'(rd_a), 32'd0);
        check("rst rpc", rpc_a, 32'h0);
        rd(CSR_MTVEC, ra, rb);
        check("rst mtvec a", ra, 32'h0);
        check("rst mtvec b", rb, 32'h100);
        rd(CSR_MEPC, ra, rb);
        check("rst mepc", ra, 32'h0);
        rd(CSR_MCAUSE, ra, rb);
        check("rst mcause", ra, 32'h0);

        // Table-driven single events.
        csr_wr(CSR_MTVEC, 32'h200);
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // mret returns to a software-written mepc (low bits forced to 0).
        csr_wr(CSR_MEPC, 32'h303);
        rd(CSR_MEPC, ra, rb);
        check("mepc align", ra, 32'h300);
        v = '{"mret0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h604, 1'b0, 1'b1, 32'h300, 32'd2, 32'h300};
        run_vec(v);

        // Wrong-path events during FLUSH and REDIRECT are ignored.
        trap0 = 1'b1; pc0 = 32'h500;
        tick();
        clear_ev();
        trap1 = 1'b1; pc1 = 32'h600;
        #1;
        check("wp kill1 in flush", 32'(k1_a), 32'd0);
        tick();
        clear_ev();
        check("wp redir", 32'(rd_a), 32'd1);
        check("wp rpc", rpc_a, 32'h200);
        trap0 = 1'b1; pc0 = 32'h700;
        #1;
        check("wp kill0 in redir", 32'(k0_a), 32'd0);
        tick();
        clear_ev();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (rd_a || fl_a) n++;
            tick();
        end
        check("wp extra redirects", 32'(n), 32'd0);
        rd(CSR_MEPC, ra, rb);
        check("wp mepc", ra, 32'h500);

        // mtvec write in the trap cycle: target uses old mtvec.
        trap0 = 1'b1; pc0 = 32'h010;
        csr_set(1'b1, CSR_MTVEC, 32'h804);
        tick();
        clear_ev();
        csr_set(1'b0, 12'h000, 32'h0);
        tick();
        check("mtvec@T rpc", rpc_a, 32'h200);
        tick();
        rd(CSR_MTVEC, ra, rb);
        check("mtvec@T new", ra, 32'h804);

        // Hardware mepc update beats a same-cycle software write.
        trap0 = 1'b1; pc0 = 32'h020;
        csr_set(1'b1, CSR_MEPC, 32'h99C);
        tick();
        clear_ev();
        csr_set(1'b0, 12'h000, 32'h0);
        tick();
        check("hwprio rpc", rpc_a, 32'h804);
        tick();
        rd(CSR_MEPC, ra, rb);
        check("hwprio mepc", ra, 32'h020);

        // Plain mcause write and a dropped unmapped write.
        csr_wr(CSR_MCAUSE, 32'h0B);
        rd(CSR_MCAUSE, ra, rb);
        check("mcause wr", ra, 32'h0B);
        csr_wr(12'h300, 32'hFFFF);
        rd(12'h300, ra, rb);
        check("unmapped rd", ra, 32'h0);
        rd(CSR_MTVEC, ra, rb);
        check("unmapped no side", ra, 32'h804);

        // FLUSH_CYCLES=3 instance: full sequence, then reset mid-flush.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        csr_wr(CSR_MTVEC, 32'h403);
        trap0 = 1'b1; pc0 = 32'h010;
        tick();
        clear_ev();
        check("b flush1", 32'(fl_b), 32'd1);
        tick();
        check("b flush2", 32'(fl_b), 32'd1);
        tick();
        check("b flush3", 32'(fl_b), 32'd1);
        check("b redir early", 32'(rd_b), 32'd0);
        tick();
        check("b flush end", 32'(fl_b), 32'd0);
        check("b redir", 32'(rd_b), 32'd1);
        check("b rpc", rpc_b, 32'h400);
        tick();
        trap0 = 1'b1; pc0 = 32'h014;
        tick();
        clear_ev();
        tick();
        check("b mid flush", 32'(fl_b), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("b rst flush", 32'(fl_b), 32'd0);
        check("b rst stall", 32'(st_b), 32'd0);
        check("b rst redir", 32'(rd_b), 32'd0);
        check("b rst rpc", rpc_b, 32'h0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_b || fl_b || st_b) n++;
        end
        check("b no redirect after rst", 32'(n), 32'd0);
        rd(CSR_MTVEC, ra, rb);
        check("b rst mtvec", rb, 32'h100);
        rd(CSR_MEPC, ra, rb);
        check("b rst mepc", rb, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
